// File: rtl/adc_if_pkg.sv
// Shared definitions for the multi-channel serial ADC interface: FSM state
// encoding, default parameter values and a small constant helper.
package adc_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_DATA  = 2'd2,
        ST_QUIET = 2'd3
    } adc_state_e;

    localparam int DEF_N_CH         = 2;
    localparam int DEF_DATA_W       = 12;
    localparam int DEF_LEAD_BITS    = 1;
    localparam int DEF_QUIET_CYCLES = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc_shift_chan.sv
// One ADC channel: MSB-first shift register plus a sticky flag that records
// any 1 seen on the line during the leading (expected-zero) bits.
module adc_shift_chan #(
    parameter int DATA_W = 12
) (
    input  logic              sck,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              lead_en,
    input  logic              shift_en,
    input  logic              miso,
    output logic [DATA_W-1:0] word_next,
    output logic              lead_err
);

    // Holds the DATA_W-1 bits already received; the final bit is appended
    // combinationally so the full word is ready on the edge that samples it.
    logic [DATA_W-2:0] sh_q;

    assign word_next = {sh_q, miso};

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            sh_q     <= '0;
            lead_err <= 1'b0;
        end else begin
            if (shift_en) begin
                sh_q <= word_next[DATA_W-2:0];
            end
            if (clear) begin
                lead_err <= 1'b0;
            end else if (lead_en && miso) begin
                lead_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_multi_if.sv
// Shared-clock, shared-chip-select reader for N_CH serial ADCs (sck is the
// only clock). Optional saturating error-frame counter: ADC_MULTI_IF_ERR_CNT_EN.
module adc_multi_if
    import adc_if_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LEAD_BITS    = DEF_LEAD_BITS,
    parameter int QUIET_CYCLES = DEF_QUIET_CYCLES
) (
    input  logic                   sck,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   cont_i,
    input  logic [N_CH-1:0]        miso,
    output logic                   cs_n,
    output logic [N_CH*DATA_W-1:0] data_o,
    output logic                   valid_o,
    output logic [N_CH-1:0]        error_o,
    output logic                   busy_o,
    output logic [15:0]            err_cnt_o,
    output adc_state_e             state_o
);

    localparam int CNT_W = $clog2(max3(LEAD_BITS, DATA_W, QUIET_CYCLES) + 1);
    localparam adc_state_e FIRST_ST = (LEAD_BITS == 0) ? ST_DATA : ST_LEAD;

    adc_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic                   go, lead_last, data_last, quiet_last;
    logic                   cs_low_d, frame_start, deliver, lead_en, shift_en;
    logic [N_CH*DATA_W-1:0] word_next;
    logic [N_CH-1:0]        chan_err;

    assign go         = start_i | cont_i;
    assign lead_last  = (cnt_q == CNT_W'(LEAD_BITS - 1));
    assign data_last  = (cnt_q == CNT_W'(DATA_W - 1));
    assign quiet_last = (cnt_q == CNT_W'(QUIET_CYCLES - 1));

    // State register; the phase counter restarts on every state change.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || state_q == ST_IDLE) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go) state_d = FIRST_ST;
            ST_LEAD:  if (lead_last) state_d = ST_DATA;
            ST_DATA:  if (data_last) state_d = ST_QUIET;
            ST_QUIET: if (quiet_last) state_d = go ? FIRST_ST : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cs_low_d    = (state_d == ST_LEAD) || (state_d == ST_DATA);
        frame_start = cs_low_d && (state_q != ST_LEAD) && (state_q != ST_DATA);
        lead_en     = (state_q == ST_LEAD);
        shift_en    = (state_q == ST_DATA);
        deliver     = (state_q == ST_DATA) && data_last;
        busy_o      = (state_q != ST_IDLE);
        state_o     = state_q;
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        adc_shift_chan #(.DATA_W(DATA_W)) u_chan (
            .sck       (sck),
            .rst_n     (rst_n),
            .clear     (frame_start),
            .lead_en   (lead_en),
            .shift_en  (shift_en),
            .miso      (miso[c]),
            .word_next (word_next[c*DATA_W +: DATA_W]),
            .lead_err  (chan_err[c])
        );
    end

    // valid_o is a one-cycle strobe with no back-pressure: data_o/error_o are
    // updated on the same edge and held until the next strobe.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            cs_n    <= 1'b1;
            valid_o <= 1'b0;
            data_o  <= '0;
            error_o <= '0;
        end else begin
            cs_n    <= ~cs_low_d;
            valid_o <= deliver;
            if (deliver) begin
                data_o  <= word_next;
                error_o <= chan_err;
            end
        end
    end

`ifdef ADC_MULTI_IF_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (deliver && (|chan_err) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_adc_multi_if.sv
// Directed bench for adc_multi_if: default 2-channel instance plus a
// 4-channel / 16-bit / 4-lead-bit instance, each fed by a behavioural ADC.
module tb_adc_multi_if;
    import adc_if_pkg::*;

    logic        sck = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        cont_i = 1'b0;
    logic [1:0]  miso = '0;
    logic        cs_n;
    logic [23:0] data_o;
    logic        valid_o;
    logic [1:0]  error_o;
    logic        busy_o;
    logic [15:0] err_cnt_o;
    adc_state_e  state_o;

    logic        start4 = 1'b0;
    logic [3:0]  miso4 = '0;
    logic        cs_n4;
    logic [63:0] data4;
    logic        valid4;
    logic [3:0]  error4;
    logic        busy4;
    logic [15:0] err_cnt4;
    adc_state_e  state4;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int exp_cnt = 0;

    // ---------------- clock / reset ----------------
    always #5 sck = ~sck;
    always @(posedge sck) cyc++;

    adc_multi_if dut (
        .sck(sck), .rst_n(rst_n), .start_i(start_i), .cont_i(cont_i), .miso(miso),
        .cs_n(cs_n), .data_o(data_o), .valid_o(valid_o), .error_o(error_o),
        .busy_o(busy_o), .err_cnt_o(err_cnt_o), .state_o(state_o)
    );

    adc_multi_if #(.N_CH(4), .DATA_W(16), .LEAD_BITS(4), .QUIET_CYCLES(2)) dut4 (
        .sck(sck), .rst_n(rst_n), .start_i(start4), .cont_i(1'b0), .miso(miso4),
        .cs_n(cs_n4), .data_o(data4), .valid_o(valid4), .error_o(error4),
        .busy_o(busy4), .err_cnt_o(err_cnt4), .state_o(state4)
    );

    // ---------------- behavioural ADCs ----------------
    logic [12:0] frm0 = '0, frm1 = '0;
    logic [19:0] f4 [4];
    int idx2 = 0;
    int idx4 = 0;

    always @(negedge sck) begin
        if (cs_n) begin
            idx2 = 0;
        end else if (idx2 <= 12) begin
            miso[0] = frm0[12-idx2];
            miso[1] = frm1[12-idx2];
            idx2++;
        end
        if (cs_n4) begin
            idx4 = 0;
        end else if (idx4 <= 19) begin
            for (int c = 0; c < 4; c++) miso4[c] = f4[c][19-idx4];
            idx4++;
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int err_inc(input logic [1:0] e);
`ifdef ADC_MULTI_IF_ERR_CNT_EN
        return (e != 2'b00) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge sck); start_i = 1'b1;
        @(negedge sck); start_i = 1'b0;
    endtask

    // Starts one frame and waits (bounded) for valid_o, counting cs_n-low cycles.
    task automatic do_frame(input logic [11:0] d0, input logic [11:0] d1,
                            input logic l0, input logic l1,
                            output int low_cnt, output bit seen);
        frm0 = {l0, d0};
        frm1 = {l1, d1};
        low_cnt = 0;
        seen = 1'b0;
        pulse_start();
        for (int k = 0; k < 40; k++) begin
            if (valid_o) begin
                seen = 1'b1;
                break;
            end
            if (!cs_n) low_cnt++;
            @(negedge sck);
        end
    endtask

    typedef struct {
        logic [11:0] d0;
        logic [11:0] d1;
        logic        l0;
        logic        l1;
        logic [23:0] exp_data;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs [5];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int low_cnt;
        bit seen;
        int nv;
        int vt [3];
        int hr;
        bit low_seen;
        int gaps [$];
        int stray;
        bit cs_bad;
        logic [23:0] held;

        vecs[0] = '{12'h48F, 12'hB70, 1'b0, 1'b0, 24'hB70_48F, 2'b00};
        vecs[1] = '{12'h48F, 12'hB70, 1'b0, 1'b1, 24'hB70_48F, 2'b10};
        vecs[2] = '{12'hFFF, 12'h000, 1'b1, 1'b0, 24'h000_FFF, 2'b01};
        vecs[3] = '{12'hA5A, 12'h5A5, 1'b1, 1'b1, 24'h5A5_A5A, 2'b11};
        vecs[4] = '{12'h001, 12'h800, 1'b0, 1'b0, 24'h800_001, 2'b00};
        f4[0] = {4'h0, 16'h1234};
        f4[1] = {4'h0, 16'hABCD};
        f4[2] = {4'h0, 16'h0F0F};
        f4[3] = {4'h0, 16'h8001};

        // Reset state
        repeat (3) @(negedge sck);
        check("rst_cs_n", 64'(cs_n), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        check("rst_state", 64'(state_o), 64'(ST_IDLE));
        rst_n = 1'b1;
        repeat (3) @(negedge sck);
        check("idle_no_start", 64'(cs_n), 64'd1);

        // Table-driven single frames
        for (int i = 0; i < 5; i++) begin
            do_frame(vecs[i].d0, vecs[i].d1, vecs[i].l0, vecs[i].l1, low_cnt, seen);
            exp_cnt += err_inc(vecs[i].exp_err);
            check($sformatf("v%0d_seen", i), 64'(seen), 64'd1);
            check($sformatf("v%0d_low_cycles", i), 64'(low_cnt), 64'd13);
            check($sformatf("v%0d_data", i), 64'(data_o), 64'(vecs[i].exp_data));
            check($sformatf("v%0d_error", i), 64'(error_o), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_cs_n_at_valid", i), 64'(cs_n), 64'd1);
            @(negedge sck);
            check($sformatf("v%0d_err_cnt", i), 64'(err_cnt_o), 64'(exp_cnt));
            check($sformatf("v%0d_valid_one_cycle", i), 64'(valid_o), 64'd0);
            check($sformatf("v%0d_data_hold", i), 64'(data_o), 64'(vecs[i].exp_data));
            @(negedge sck);
            check($sformatf("v%0d_idle_busy", i), 64'(busy_o), 64'd0);
        end

        // Continuous mode: three frames, cont_i dropped mid third frame
        frm0 = {1'b0, 12'h123};
        frm1 = {1'b0, 12'h456};
        nv = 0; hr = 0; low_seen = 1'b0; stray = 0;
        @(negedge sck); cont_i = 1'b1;
        for (int k = 0; k < 100 && nv < 3; k++) begin
            @(negedge sck);
            if (nv == 2) begin
                stray++;
                if (stray == 6) cont_i = 1'b0;
            end
            if (valid_o) begin
                vt[nv] = cyc;
                nv++;
                check($sformatf("cont_data%0d", nv), 64'(data_o), 64'h456_123);
            end
            if (cs_n) begin
                if (low_seen) hr++;
            end else begin
                if (low_seen && hr > 0) gaps.push_back(hr);
                hr = 0;
                low_seen = 1'b1;
            end
        end
        cont_i = 1'b0;
        check("cont_valid_count", 64'(nv), 64'd3);
        check("cont_period_1_2", 64'(vt[1] - vt[0]), 64'd15);
        check("cont_period_2_3", 64'(vt[2] - vt[1]), 64'd15);
        check("cont_gap_count", 64'(gaps.size()), 64'd2);
        if (gaps.size() == 2) begin
            check("cont_gap1", 64'(gaps[0]), 64'd2);
            check("cont_gap2", 64'(gaps[1]), 64'd2);
        end
        stray = 0;
        repeat (30) begin
            @(negedge sck);
            if (valid_o || !cs_n) stray++;
        end
        check("cont_stops_after_drop", 64'(stray), 64'd0);
        check("cont_idle_busy", 64'(busy_o), 64'd0);

        // Reset during the 6th data bit
        frm0 = {1'b0, 12'hFFF};
        frm1 = {1'b0, 12'hFFF};
        pulse_start();
        repeat (6) @(negedge sck);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_cs_n", 64'(cs_n), 64'd1);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_data", 64'(data_o), 64'd0);
        check("midrst_err_cnt", 64'(err_cnt_o), 64'd0);
        exp_cnt = 0;
        @(negedge sck); rst_n = 1'b1;
        stray = 0; cs_bad = 1'b0;
        repeat (30) begin
            @(negedge sck);
            if (valid_o) stray++;
            if (!cs_n) cs_bad = 1'b1;
        end
        check("midrst_no_valid", 64'(stray), 64'd0);
        check("midrst_no_frame", 64'(cs_bad), 64'd0);
        do_frame(vecs[1].d0, vecs[1].d1, vecs[1].l0, vecs[1].l1, low_cnt, seen);
        check("postrst_seen", 64'(seen), 64'd1);
        check("postrst_data", 64'(data_o), 64'h B70_48F);
        check("postrst_error", 64'(error_o), 64'b10);
        exp_cnt += err_inc(2'b10);
        @(negedge sck);
        check("postrst_err_cnt", 64'(err_cnt_o), 64'(exp_cnt));

        // start_i pulses during DATA are ignored
        frm0 = {1'b0, 12'h3C3};
        frm1 = {1'b0, 12'h0F1};
        held = 24'h0;
        stray = 0;
        @(negedge sck); start_i = 1'b1;
        for (int k = 1; k < 46; k++) begin
            @(negedge sck);
            start_i = (k == 4 || k == 9 || k == 12);
            if (valid_o) begin
                stray++;
                held = data_o;
            end
        end
        start_i = 1'b0;
        check("ign_valid_count", 64'(stray), 64'd1);
        check("ign_data", 64'(held), 64'h0F1_3C3);
        check("ign_idle_state", 64'(state_o), 64'(ST_IDLE));

        // Wide instance: 4 channels x 16 bits, 4 lead bits
        low_cnt = 0; seen = 1'b0;
        @(negedge sck); start4 = 1'b1;
        @(negedge sck); start4 = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (valid4) begin
                seen = 1'b1;
                break;
            end
            if (!cs_n4) low_cnt++;
            @(negedge sck);
        end
        check("w4_seen", 64'(seen), 64'd1);
        check("w4_low_cycles", 64'(low_cnt), 64'd20);
        check("w4_data", data4, 64'h8001_0F0F_ABCD_1234);
        check("w4_error", 64'(error4), 64'd0);
        check("w4_err_cnt", 64'(err_cnt4), 64'd0);
        repeat (4) @(negedge sck);
        check("w4_idle", 64'(busy4), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_multi_if.md
ADC_MULTI_IF -- requirements
Module: adc_multi_if

Interface
REQ-001 Parameter N_CH, default 2, number of parallel ADC serial data lines sharing sck and cs_n.
REQ-002 Parameter DATA_W, default 12, data bits per conversion, MSB first.
REQ-003 Parameter LEAD_BITS, default 1, leading bits per frame, expected 0 from the ADC, range 0..7.
REQ-004 Parameter QUIET_CYCLES, default 2, sck cycles cs_n stays high between frames, range 1..255.
REQ-005 sck  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start_i  input  1  single-shot conversion request, sampled in IDLE or the last QUIET cycle.
REQ-008 cont_i  input  1  continuous mode; while high, frames run back-to-back.
REQ-009 miso  input  N_CH  serial data, bit c from ADC c; changes on falling sck edge.
REQ-010 cs_n  output  1  shared chip select, registered, active low.
REQ-011 data_o  output  N_CH*DATA_W  channel c in bits [c*DATA_W +: DATA_W].
REQ-012 valid_o  output  1  one-cycle pulse marking new data_o/error_o.
REQ-013 error_o  output  N_CH  per-channel leading-bit violation for the frame just delivered.
REQ-014 busy_o  output  1  high whenever state is not IDLE.
REQ-015 err_cnt_o  output  16  saturating error-frame count (see Configuration).

Function
REQ-016 FSM states IDLE, LEAD, DATA, QUIET; cs_n low exactly in LEAD and DATA.
REQ-017 IDLE: start_i or cont_i high at a rising edge -> LEAD (or DATA if LEAD_BITS=0); cs_n goes low at that edge.
REQ-018 LEAD: LEAD_BITS edges, each sampling miso; any sampled 1 on channel c sets that channel's error flag.
REQ-019 DATA: DATA_W edges sampling miso MSB first into per-channel shift registers.
REQ-020 Edge sampling the last data bit: cs_n<=1, data_o<=assembled words, error_o<=flags, valid_o<=1, state<=QUIET.
REQ-021 Frame length with cs_n low: exactly LEAD_BITS+DATA_W cycles; valid_o high the cycle after the last data bit is sampled.
REQ-022 valid_o deasserts after one cycle; data_o and error_o hold until the next valid_o.
REQ-023 QUIET: QUIET_CYCLES cycles; at the last one, start_i or cont_i high -> LEAD/DATA directly, else IDLE.
REQ-024 start_i outside IDLE and outside the last QUIET cycle is ignored; not queued.
REQ-025 cont_i dropping mid-frame completes the current frame, then returns to IDLE.
REQ-026 Error flags clear at frame start; a violation still delivers data_o unchanged.
REQ-027 Bit counter width $clog2(max(LEAD_BITS,DATA_W,QUIET_CYCLES)+1); no wrap within a phase.

Reset
REQ-028 rst_n low: state IDLE, cs_n=1, valid_o=0, data_o=0, error_o=0, busy_o=0, err_cnt_o=0, immediately and asynchronously.
REQ-029 Reset mid-frame aborts the frame; no valid_o for it; first frame after release starts only on start_i/cont_i.

Configuration
REQ-030 Macro ADC_MULTI_IF_ERR_CNT_EN defined: err_cnt_o increments by 1 on each valid_o with any error_o bit set, saturating at 16'hFFFF.
REQ-031 Macro undefined: err_cnt_o tied to 0, no counter logic; all other behaviour identical.

Structure
REQ-032 Package adc_if_pkg holds the FSM state enum and default parameter constants.
REQ-033 Sub-module adc_shift_chan (one channel: shift register plus lead-error flag) instantiated N_CH times via generate.

Verification
REQ-034 Defaults, start_i pulse, ch0 bits 0x48F, ch1 0xB70, lead 0 -> after 13 low cycles valid_o=1, data_o={12'hB70,12'h48F}, error_o=2'b00.
REQ-035 Same frame with ch1 lead bit 1 -> error_o=2'b10, data unchanged; err_cnt_o=1 with macro, 0 without.
REQ-036 cont_i held high, 3 frames -> cs_n high exactly 2 cycles between frames, 3 valid_o pulses 15 cycles apart.
REQ-037 rst_n low at 6th data bit -> cs_n=1 same cycle, no valid_o; after release no frame until start_i.
REQ-038 Params N_CH=4, DATA_W=16, LEAD_BITS=4 -> 20 low cycles, four 16-bit words correct.
REQ-039 start_i pulses during DATA -> ignored; exactly one valid_o, return to IDLE.
